mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage of the 5-stage in-order LoongArch core.
- Latches the 103-bit EXE_to_MEM bus under the valid/allow_in handshake.
- Takes load data from the synchronous data SRAM and applies byte/half/word selection plus sign/zero extension (decoded from inst).
- Drives the 70-bit MEM_to_WB bus and a forwarding/load-use bus back to decode.

Parameters:
- EM_BUS_W, 103, width of EXE_to_MEM bus
- MW_BUS_W, 70, width of MEM_to_WB bus
- FWD_W, 39, width of MEM_fwd_bus

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- EXE_to_MEM_valid  in  1  execute stage holds a valid instruction
- MEM_allow_in  out  1  this stage can accept this cycle
- EXE_to_MEM_bus  in  103  {alu_result[102:71], res_from_mem[70], gr_we[69], dest[68:64], pc[63:32], inst[31:0]}
- data_sram_rdata  in  32  SRAM read data; valid the cycle after the address was presented in EXE
- MEM_to_WB_valid  out  1  valid instruction offered to WB
- WB_allow_in  in  1  WB can accept
- MEM_to_WB_bus  out  70  {final_result[69:38], gr_we[37], dest[36:32], pc[31:0]}
- MEM_fwd_bus  out  39  {fwd_we[38], dest[37:33], final_result[32:1], is_load[0]} to ID for bypass and stall

Behaviour:
- Reset (resetn=0 at posedge clk):
  - MEM_valid, bus register, hold_vld and rdata_hold all clear to 0.
  - Outputs after reset: MEM_to_WB_valid=0, MEM_to_WB_bus=0, MEM_fwd_bus=0, MEM_allow_in=1.
- Handshake:
  - ready_go=1.
  - MEM_allow_in = ~MEM_valid | WB_allow_in.
  - MEM_to_WB_valid = MEM_valid.
  - When MEM_allow_in=1, MEM_valid <= EXE_to_MEM_valid.
  - The bus register loads only when EXE_to_MEM_valid & MEM_allow_in.
  - Latency: one cycle per stage when WB does not stall.
- Read-data hold (required because the SRAM is always enabled and re-reads while EXE stalls):
  - On accept, hold_vld <= 0.
  - If MEM_valid & ~hold_vld & ~WB_allow_in, then rdata_hold <= data_sram_rdata and hold_vld <= 1.
  - mem_word = hold_vld ? rdata_hold : data_sram_rdata.
  - The value is stable for any stall length.
- Load decode from inst[31:22]:
  - 0x0A0 ld.b: signed byte
  - 0x0A1 ld.h: signed half
  - 0x0A2 ld.w: word
  - 0x0A8 ld.bu: zero-extended byte
  - 0x0A9 ld.hu: zero-extended half
  - Any other opcode with res_from_mem=1 is treated as ld.w.
- Lane selection:
  - Byte: selected by alu_result[1:0] (0 → [7:0] … 3 → [31:24]).
  - Half: selected by alu_result[1] (0 → [15:0], 1 → [31:16]); alu_result[0] is ignored (no alignment exception in this stage).
- final_result = res_from_mem ? load_data : alu_result.
- Forwarding:
  - fwd_we = MEM_valid & gr_we & (dest != 0).
  - is_load = MEM_valid & res_from_mem.
  - dest=0 never forwards.
- Simultaneous events:
  - Accept and drain in the same cycle replace the bus register; the hold is cleared.
  - Reset mid-stall drops the instruction and the held data.

Decomposition:
- Shared package (pipeline_defs):
  - Bus widths EM_BUS_W, MW_BUS_W, FWD_W.
  - Bit-position constants for each bus field.
  - Load opcode constants OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU.
- One natural sub-module: load_extend (combinational). Inputs: inst[31:22], addr[1:0], word. Output: 32-bit extended data.

Test Plan:
- Reset held for 3 cycles → MEM_allow_in=1, MEM_to_WB_valid=0, MEM_fwd_bus=0, MEM_to_WB_bus=0.
- ALU op: alu_result=0x1234_5678, gr_we=1, dest=5, res_from_mem=0, WB_allow_in=1 → next cycle MEM_to_WB_bus final_result=0x1234_5678, dest=5; fwd_we=1, is_load=0.
- ld.b at addr 0x...03 with rdata=0x8000_0000 → final_result=0xFFFF_FF80. Same case as ld.bu → 0x0000_0080.
- ld.h at addr 0x...02 with rdata=0xABCD_1234 → 0xFFFF_ABCD. Same case as ld.hu → 0x0000_ABCD.
- ld.w with rdata=0xDEAD_BEEF, WB_allow_in=0 for 4 cycles while rdata changes to 0x0 → MEM_allow_in=0 throughout; on release MEM_to_WB_bus final_result=0xDEAD_BEEF.
- gr_we=1, dest=0 → fwd_we=0. resetn=0 during a stalled load → MEM_to_WB_valid=0 on the next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, field
// positions inside the EXE->MEM bus, load opcodes and the load-kind decoder.
// No ports (package).
package mem_stage_pkg;

  localparam int EM_BUS_W = 103;
  localparam int MW_BUS_W = 70;
  localparam int FWD_W    = 39;

  // EXE->MEM bus field positions
  localparam int EM_ALU_MSB   = 102;
  localparam int EM_ALU_LSB   = 71;
  localparam int EM_FROM_MEM  = 70;
  localparam int EM_GR_WE     = 69;
  localparam int EM_DEST_MSB  = 68;
  localparam int EM_DEST_LSB  = 64;
  localparam int EM_PC_MSB    = 63;
  localparam int EM_PC_LSB    = 32;
  localparam int EM_OP_MSB    = 31;
  localparam int EM_OP_LSB    = 22;

  // Load opcodes, inst[31:22]
  localparam logic [9:0] OP_LD_B  = 10'h0A0;
  localparam logic [9:0] OP_LD_H  = 10'h0A1;
  localparam logic [9:0] OP_LD_W  = 10'h0A2;
  localparam logic [9:0] OP_LD_BU = 10'h0A8;
  localparam logic [9:0] OP_LD_HU = 10'h0A9;

  typedef enum logic [2:0] {
    LK_B  = 3'd0,
    LK_H  = 3'd1,
    LK_W  = 3'd2,
    LK_BU = 3'd3,
    LK_HU = 3'd4
  } load_kind_e;

  // Unknown opcodes fall back to a full word so a mis-decoded load still
  // returns the raw SRAM data rather than a truncated value.
  function automatic load_kind_e decode_load(input logic [9:0] op);
    load_kind_e k;
    case (op)
      OP_LD_B:  k = LK_B;
      OP_LD_H:  k = LK_H;
      OP_LD_BU: k = LK_BU;
      OP_LD_HU: k = LK_HU;
      default:  k = LK_W;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side signals of the memory stage.
// Handshake: a transfer EXE->MEM happens on a rising edge where
// EXE_to_MEM_valid & MEM_allow_in; MEM->WB transfers where
// MEM_to_WB_valid & WB_allow_in. Allow signals never depend on the
// incoming valid of the same link.
//   slave  : the memory stage's view
//   master : the surrounding pipeline / environment view
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                EXE_to_MEM_valid;
  logic                MEM_allow_in;
  logic [EM_BUS_W-1:0] EXE_to_MEM_bus;
  logic [31:0]         data_sram_rdata;
  logic                MEM_to_WB_valid;
  logic                WB_allow_in;
  logic [MW_BUS_W-1:0] MEM_to_WB_bus;
  logic [FWD_W-1:0]    MEM_fwd_bus;

  modport slave (
    input  EXE_to_MEM_valid, EXE_to_MEM_bus, data_sram_rdata, WB_allow_in,
    output MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus, MEM_fwd_bus
  );

  modport master (
    output EXE_to_MEM_valid, EXE_to_MEM_bus, data_sram_rdata, WB_allow_in,
    input  MEM_allow_in, MEM_to_WB_valid, MEM_to_WB_bus, MEM_fwd_bus
  );
endinterface

// File: rtl/mem_stage_load_extend.sv
// Combinational load formatter: picks the byte/half lane addressed by the
// low address bits and sign- or zero-extends it according to the opcode.
//   i_op   : inst[31:22]
//   i_addr : effective address [1:0]
//   i_word : 32-bit SRAM word
//   o_data : extended load result
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [9:0]  i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  // Address bit 0 is ignored for halves; misalignment is handled elsewhere.
  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (decode_load(i_op))
      LK_B:    o_data = {{24{w_byte[7]}}, w_byte};
      LK_BU:   o_data = {24'h0, w_byte};
      LK_H:    o_data = {{16{w_half[15]}}, w_half};
      LK_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage (EXE -> MEM -> WB).
// Latches the EXE->MEM bus, formats load data from the synchronous data SRAM,
// and drives the MEM->WB bus plus a bypass/load-use bus back to decode.
//   clk    : clock
//   resetn : synchronous active-low reset
//   bus_if : pipeline handshake, buses and SRAM read data (slave modport)
module mem_stage
  import mem_stage_pkg::*;
(
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave bus_if
);

  logic                r_mem_valid;
  logic [EM_BUS_W-1:0] r_bus;
  logic                r_hold_vld;
  logic [31:0]         r_rdata_hold;

  logic        w_allow_in;
  logic        w_accept;
  logic [31:0] w_mem_word;
  logic [31:0] w_alu_result;
  logic        w_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_pc;
  logic [9:0]  w_op;
  logic [31:0] w_load_data;
  logic [31:0] w_final;
  logic        w_unused;

  // Stage always completes in one cycle, so it only blocks when WB does.
  assign w_allow_in = ~r_mem_valid | bus_if.WB_allow_in;
  assign w_accept   = bus_if.EXE_to_MEM_valid & w_allow_in;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem_valid  <= 1'b0;
      r_bus        <= '0;
      r_hold_vld   <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      if (w_allow_in) begin
        r_mem_valid <= bus_if.EXE_to_MEM_valid;
      end
      if (w_accept) begin
        r_bus      <= bus_if.EXE_to_MEM_bus;
        r_hold_vld <= 1'b0;
      end else if (r_mem_valid & ~r_hold_vld & ~bus_if.WB_allow_in) begin
        // The SRAM keeps re-reading whatever EXE presents while we stall, so
        // the word belonging to this instruction is captured on the first
        // stalled cycle and used until the instruction leaves.
        r_rdata_hold <= bus_if.data_sram_rdata;
        r_hold_vld   <= 1'b1;
      end
    end
  end

  assign w_mem_word   = r_hold_vld ? r_rdata_hold : bus_if.data_sram_rdata;
  assign w_alu_result = r_bus[EM_ALU_MSB:EM_ALU_LSB];
  assign w_from_mem   = r_bus[EM_FROM_MEM];
  assign w_gr_we      = r_bus[EM_GR_WE];
  assign w_dest       = r_bus[EM_DEST_MSB:EM_DEST_LSB];
  assign w_pc         = r_bus[EM_PC_MSB:EM_PC_LSB];
  assign w_op         = r_bus[EM_OP_MSB:EM_OP_LSB];
  assign w_unused     = ^r_bus[EM_OP_LSB-1:0];

  mem_stage_load_extend u_load_extend (
    .i_op   (w_op),
    .i_addr (w_alu_result[1:0]),
    .i_word (w_mem_word),
    .o_data (w_load_data)
  );

  assign w_final = w_from_mem ? w_load_data : w_alu_result;

  assign bus_if.MEM_allow_in    = w_allow_in;
  assign bus_if.MEM_to_WB_valid = r_mem_valid;
  assign bus_if.MEM_to_WB_bus   = {w_final, w_gr_we, w_dest, w_pc};
  // r0 is hardwired to zero, so a write to it must never be bypassed.
  assign bus_if.MEM_fwd_bus     = {r_mem_valid & w_gr_we & (w_dest != 5'd0),
                                   w_dest, w_final, r_mem_valid & w_from_mem};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic clk;
  logic resetn;
  mem_stage_if intf();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus_if (intf.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks;
  int failures;
  bit chk_en;
  logic [69:0] exp_q[$];
  logic [38:0] fexp_q[$];
  bit          pend;
  logic [31:0] pend_word;
  logic [31:0] cur_word;
  bit          idle_zero;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [102:0] mk_bus(input logic [31:0] alu, input logic fm,
                                          input logic we, input logic [4:0] dest,
                                          input logic [31:0] pc, input logic [31:0] inst);
    return {alu, fm, we, dest, pc, inst};
  endfunction

  function automatic logic [31:0] ref_final(input logic [102:0] b, input logic [31:0] word);
    logic [31:0] alu;
    logic [9:0]  op;
    logic [31:0] v;
    alu = b[102:71];
    op  = b[31:22];
    if (!b[70]) return alu;
    if (op == 10'h0A0 || op == 10'h0A8) begin
      v = (word >> (int'(alu[1:0]) * 8)) & 32'hFF;
      if (op == 10'h0A0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (op == 10'h0A1 || op == 10'h0A9) begin
      v = (word >> (int'(alu[1]) * 16)) & 32'hFFFF;
      if (op == 10'h0A1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    return word;
  endfunction

  function automatic logic [102:0] rand_bus();
    logic [9:0] ops[7];
    int k;
    logic [9:0] op;
    logic fm;
    ops = '{10'h0A0, 10'h0A1, 10'h0A2, 10'h0A8, 10'h0A9, 10'h0A6, 10'h004};
    k  = $urandom_range(0, 6);
    op = ops[k];
    fm = (k != 6);
    return mk_bus($urandom, fm, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom, {op, 22'($urandom)});
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs for the coming cycle; the SRAM returns the accepted instruction's
  // word in its first MEM cycle and unrelated data afterwards.
  task automatic apply(input logic v, input logic [102:0] b, input logic [31:0] w,
                       input logic wb, input logic rn);
    intf.EXE_to_MEM_valid = v;
    intf.EXE_to_MEM_bus   = b;
    intf.WB_allow_in      = wb;
    resetn                = rn;
    cur_word              = w;
    if (pend) intf.data_sram_rdata = pend_word;
    else      intf.data_sram_rdata = idle_zero ? 32'h0 : $urandom;
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    if (!resetn) begin
      exp_q.delete();
      fexp_q.delete();
      pend = 0;
    end else begin
      acc = intf.EXE_to_MEM_valid && (exp_q.size() == 0 || intf.WB_allow_in);
      if (exp_q.size() != 0 && intf.WB_allow_in) begin
        void'(exp_q.pop_front());
        void'(fexp_q.pop_front());
      end
      pend = 0;
      if (acc) begin
        logic [31:0] f;
        logic [102:0] b;
        b = intf.EXE_to_MEM_bus;
        f = ref_final(b, cur_word);
        exp_q.push_back({f, b[69], b[68:64], b[63:32]});
        fexp_q.push_back({b[69] && (b[68:64] != 5'd0), b[68:64], f, b[70]});
        pend = 1;
        pend_word = cur_word;
      end
    end
    #1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 70'(intf.MEM_to_WB_valid), 70'(exp_q.size() != 0));
      chk("allow_in", 70'(intf.MEM_allow_in), 70'(exp_q.size() == 0 || intf.WB_allow_in));
      if (exp_q.size() != 0) begin
        chk("mw_bus", intf.MEM_to_WB_bus, exp_q[0]);
        chk("fwd_bus", 70'(intf.MEM_fwd_bus), 70'(fexp_q[0]));
      end else begin
        chk("fwd_idle", 70'({intf.MEM_fwd_bus[38], intf.MEM_fwd_bus[0]}), 70'(0));
      end
    end
  end

  task automatic issue_check(input string name, input logic [102:0] b,
                             input logic [31:0] w, input logic [31:0] exp_final);
    apply(1, b, w, 1, 1);
    tick();
    apply(0, '0, 32'h0, 1, 1);
    @(negedge clk);
    chk(name, 70'(intf.MEM_to_WB_bus[69:38]), 70'(exp_final));
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0; chk_en = 0; pend = 0; idle_zero = 0;
    pend_word = 0; cur_word = 0;

    apply(0, '0, 32'h0, 1, 0);
    tick();
    chk_en = 1;
    tick();
    tick();
    apply(0, '0, 32'h0, 1, 1);
    @(negedge clk);
    chk("rst_allow_in", 70'(intf.MEM_allow_in), 70'(1));
    chk("rst_valid", 70'(intf.MEM_to_WB_valid), 70'(0));
    chk("rst_mw_bus", intf.MEM_to_WB_bus, 70'(0));
    chk("rst_fwd_bus", 70'(intf.MEM_fwd_bus), 70'(0));
    tick();

    // ALU result passes straight through and is forwarded
    apply(1, mk_bus(32'h1234_5678, 0, 1, 5'd5, 32'h1C00_0000, 32'h0010_0000),
          32'h0, 1, 1);
    tick();
    apply(0, '0, 32'h0, 1, 1);
    @(negedge clk);
    chk("alu_final", 70'(intf.MEM_to_WB_bus[69:38]), 70'(32'h1234_5678));
    chk("alu_dest", 70'(intf.MEM_to_WB_bus[36:32]), 70'(5));
    chk("alu_fwd_we", 70'(intf.MEM_fwd_bus[38]), 70'(1));
    chk("alu_is_load", 70'(intf.MEM_fwd_bus[0]), 70'(0));
    tick();

    issue_check("ld_b", mk_bus(32'h1000_0003, 1, 1, 5'd7, 32'h1C00_0004, {10'h0A0, 22'h0}),
                32'h8000_0000, 32'hFFFF_FF80);
    issue_check("ld_bu", mk_bus(32'h1000_0003, 1, 1, 5'd7, 32'h1C00_0008, {10'h0A8, 22'h0}),
                32'h8000_0000, 32'h0000_0080);
    issue_check("ld_h", mk_bus(32'h1000_0002, 1, 1, 5'd8, 32'h1C00_000C, {10'h0A1, 22'h0}),
                32'hABCD_1234, 32'hFFFF_ABCD);
    issue_check("ld_hu", mk_bus(32'h1000_0002, 1, 1, 5'd8, 32'h1C00_0010, {10'h0A9, 22'h0}),
                32'hABCD_1234, 32'h0000_ABCD);

    // Load held across a 4-cycle WB stall while the SRAM output goes to zero
    apply(1, mk_bus(32'h1000_0000, 1, 1, 5'd9, 32'h1C00_0014, {10'h0A2, 22'h0}),
          32'hDEAD_BEEF, 1, 1);
    tick();
    idle_zero = 1;
    repeat (4) begin
      apply(0, '0, 32'h0, 0, 1);
      @(negedge clk);
      chk("stall_allow_in", 70'(intf.MEM_allow_in), 70'(0));
      tick();
    end
    apply(0, '0, 32'h0, 1, 1);
    @(negedge clk);
    chk("stall_release", 70'(intf.MEM_to_WB_bus[69:38]), 70'(32'hDEAD_BEEF));
    tick();
    idle_zero = 0;

    // Writes to r0 are never forwarded
    apply(1, mk_bus(32'h5555_AAAA, 0, 1, 5'd0, 32'h1C00_0018, 32'h0010_0000),
          32'h0, 1, 1);
    tick();
    apply(0, '0, 32'h0, 1, 1);
    @(negedge clk);
    chk("dest0_fwd_we", 70'(intf.MEM_fwd_bus[38]), 70'(0));
    tick();

    // Reset during a stalled load drops it
    apply(1, mk_bus(32'h1000_0000, 1, 1, 5'd3, 32'h1C00_001C, {10'h0A2, 22'h0}),
          32'hCAFE_F00D, 1, 1);
    tick();
    apply(0, '0, 32'h0, 0, 1);
    tick();
    apply(0, '0, 32'h0, 0, 0);
    tick();
    apply(0, '0, 32'h0, 0, 1);
    @(negedge clk);
    chk("rst_mid_valid", 70'(intf.MEM_to_WB_valid), 70'(0));
    chk("rst_mid_bus", intf.MEM_to_WB_bus, 70'(0));
    tick();

    // Randomized traffic with random WB back-pressure
    repeat (600) begin
      apply(1'($urandom_range(0, 3) != 0), rand_bus(), $urandom,
            1'($urandom_range(0, 3) != 0), 1);
      tick();
    end
    apply(0, '0, 32'h0, 1, 1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
